// File: rtl/mem_requester.sv
// Initiator for the single-word request/acknowledge RAM protocol: one load or
// store in flight, one-cycle request pulses, and a watchdog on the acknowledge.
module mem_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdWrite,
    input  logic [31:0] cmdAddr,
    input  logic [31:0] cmdData,
    output logic        rspValid,
    output logic        rspWrite,
    output logic [31:0] rspData,
    output logic        rspTimeout,
    output logic        busy,
    output logic [31:0] ramAddress,
    output logic [31:0] ramOut,
    output logic        readReq,
    output logic        writeReq,
    input  logic [31:0] ramValue,
    input  logic        readAck,
    input  logic        writeAck
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = TIMEOUT_CYCLES[15:0];

    state_t      state_q, state_d;
    logic [31:0] ramAddress_q, ramAddress_d;
    logic [31:0] ramOut_q, ramOut_d;
    logic [31:0] rspData_q, rspData_d;
    logic        readReq_q, readReq_d;
    logic        writeReq_q, writeReq_d;
    logic        rspValid_q, rspValid_d;
    logic        rspWrite_q, rspWrite_d;
    logic        rspTimeout_q, rspTimeout_d;
    logic        isWrite_q, isWrite_d;
    logic [15:0] cnt_q, cnt_d;
    logic        match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ramAddress_q <= '0;
            ramOut_q     <= '0;
            rspData_q    <= '0;
            readReq_q    <= 1'b0;
            writeReq_q   <= 1'b0;
            rspValid_q   <= 1'b0;
            rspWrite_q   <= 1'b0;
            rspTimeout_q <= 1'b0;
            isWrite_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ramAddress_q <= ramAddress_d;
            ramOut_q     <= ramOut_d;
            rspData_q    <= rspData_d;
            readReq_q    <= readReq_d;
            writeReq_q   <= writeReq_d;
            rspValid_q   <= rspValid_d;
            rspWrite_q   <= rspWrite_d;
            rspTimeout_q <= rspTimeout_d;
            isWrite_q    <= isWrite_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ramAddress_d = ramAddress_q;
        ramOut_d     = ramOut_q;
        rspData_d    = rspData_q;
        rspWrite_d   = rspWrite_q;
        isWrite_d    = isWrite_q;
        cnt_d        = cnt_q;
        // Pulses and strobes fall back to zero every cycle so no level is ever held.
        readReq_d    = 1'b0;
        writeReq_d   = 1'b0;
        rspValid_d   = 1'b0;
        rspTimeout_d = 1'b0;
        match        = isWrite_q ? writeAck : readAck;

        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    ramAddress_d = cmdAddr;
                    if (cmdWrite) ramOut_d = cmdData;
                    isWrite_d  = cmdWrite;
                    readReq_d  = !cmdWrite;
                    writeReq_d = cmdWrite;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (match) begin
                    rspValid_d = 1'b1;
                    rspWrite_d = isWrite_q;
                    rspData_d  = isWrite_q ? 32'd0 : ramValue;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (TIMEOUT_W != 16'd0 && cnt_d == TIMEOUT_W) begin
                        rspValid_d   = 1'b1;
                        rspTimeout_d = 1'b1;
                        rspWrite_d   = isWrite_q;
                        rspData_d    = 32'd0;
                        state_d      = ERROR;
                    end
                end
            end
            ERROR: state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    assign cmdReady   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ramAddress = ramAddress_q;
    assign ramOut     = ramOut_q;
    assign readReq    = readReq_q;
    assign writeReq   = writeReq_q;
    assign rspValid   = rspValid_q;
    assign rspWrite   = rspWrite_q;
    assign rspData    = rspData_q;
    assign rspTimeout = rspTimeout_q;

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: byte-addressed RAM responder, transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_mem_requester;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdValid = 1'b0, cmdWrite = 1'b0;
    logic [31:0] cmdAddr = '0, cmdData = '0;
    logic        cmdReady, rspValid, rspWrite, rspTimeout, busy;
    logic [31:0] rspData, ramAddress, ramOut;
    logic        readReq, writeReq;
    logic [31:0] ramValue;
    logic        readAck, writeAck;

    mem_requester #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdData(cmdData),
        .rspValid(rspValid), .rspWrite(rspWrite), .rspData(rspData),
        .rspTimeout(rspTimeout), .busy(busy),
        .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq),
        .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    // Initial RAM image: 0x10 = 12345678, 0x40/44/48 = three distinct words.
    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] w;
        case (a & 32'hFC)
            32'h10:  w = 32'h12345678;
            32'h40:  w = 32'hA1B2C3D4;
            32'h44:  w = 32'h0BADF00D;
            32'h48:  w = 32'hCAFEBABE;
            default: w = 32'h0;
        endcase
        return w[8*(a%4) +: 8];
    endfunction

    // ---------------- RAM responder: samples a request, acks two cycles later
    logic [7:0] ram [0:255];
    bit silent = 1'b0, force_rack = 1'b0, force_wack = 1'b0;
    int rpend = 0, wpend = 0;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram[8'(a + 3)], ram[8'(a + 2)], ram[8'(a + 1)], ram[8'(a)]};
    endfunction

    initial begin
        bit r, w;
        for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
        readAck = 1'b0; writeAck = 1'b0; ramValue = 32'h5A5A5A5A;
        forever begin
            @(negedge clk); #2;
            r = 1'b0; w = 1'b0;
            if (rpend > 0) begin rpend--; if (rpend == 0) r = 1'b1; end
            if (wpend > 0) begin wpend--; if (wpend == 0) w = 1'b1; end
            if (readReq && !silent) rpend = 2;
            if (writeReq && !silent) begin
                for (int i = 0; i < 4; i++) ram[8'(ramAddress + 32'(i))] = ramOut[8*i +: 8];
                wpend = 2;
            end
            readAck  = r | force_rack;
            writeAck = w | force_wack;
            ramValue = readAck ? ram_word(ramAddress) : 32'h5A5A5A5A;
        end
    end

    // ---------------- Reference model: one outstanding transaction, reference memory
    logic [7:0]  rmem [0:255];
    bit          m_pend = 1'b0, m_dead = 1'b0, m_isw = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_age = 0;
    logic [31:0] e_addr = '0, e_out = '0, e_rd = '0;
    bit          e_rr = 1'b0, e_wr = 1'b0, e_rv = 1'b0, e_rw = 1'b0, e_to = 1'b0;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {rmem[8'(a + 3)], rmem[8'(a + 2)], rmem[8'(a + 1)], rmem[8'(a)]};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            e_rr = 1'b0; e_wr = 1'b0; e_rv = 1'b0; e_to = 1'b0;
            if (reset) begin
                m_pend = 1'b0; m_dead = 1'b0;
                e_addr = '0; e_out = '0; e_rd = '0; e_rw = 1'b0;
            end else if (m_pend) begin
                if (m_isw ? writeAck : readAck) begin
                    e_rv = 1'b1; e_rw = m_isw;
                    e_rd = m_isw ? 32'd0 : ref_word(m_addr);
                    m_pend = 1'b0;
                end else begin
                    m_age++;
                    if (TO != 0 && m_age == TO) begin
                        e_rv = 1'b1; e_to = 1'b1; e_rw = m_isw; e_rd = 32'd0;
                        m_pend = 1'b0; m_dead = 1'b1;
                    end
                end
            end else if (!m_dead && cmdValid) begin
                m_pend = 1'b1; m_isw = cmdWrite; m_addr = cmdAddr; m_age = 0;
                e_addr = cmdAddr;
                if (cmdWrite) begin
                    e_out = cmdData;
                    for (int i = 0; i < 4; i++) rmem[8'(cmdAddr + 32'(i))] = cmdData[8*i +: 8];
                end
                e_rr = !cmdWrite; e_wr = cmdWrite;
            end
        end
    end

    // ---------------- Compare process and event log
    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        to;
        int          cyc;
    } rsp_t;
    rsp_t q_rsp[$];
    int n_rreq = 0, n_wreq = 0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk1("cmdReady", cmdReady, !(m_pend || m_dead));
            chk1("busy", busy, m_pend || m_dead);
            chk1("readReq", readReq, e_rr);
            chk1("writeReq", writeReq, e_wr);
            chk1("rspValid", rspValid, e_rv);
            chk1("rspTimeout", rspTimeout, e_rv && e_to);
            chk("ramAddress", ramAddress, e_addr);
            chk("ramOut", ramOut, e_out);
            if (e_rv) begin
                chk("rspData", rspData, e_rd);
                chk1("rspWrite", rspWrite, e_rw);
            end
        end
        if (readReq) n_rreq++;
        if (writeReq) n_wreq++;
        if (rspValid) q_rsp.push_back('{rspData, rspWrite, rspTimeout, cyc});
    end

    // ---------------- Stimulus helpers
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, output int acc);
        bit rdy, ok;
        @(negedge clk); #1;
        cmdValid = 1'b1; cmdWrite = w; cmdAddr = a; cmdData = d;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            rdy = cmdReady;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            else #1;
        end
        @(negedge clk);
        acc = cyc;
        #1;
        if (!hold) cmdValid = 1'b0;
        if (!ok) bound_expired("accept");
    endtask

    task automatic wait_rsp(input int n0);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); #1;
            if (q_rsp.size() > n0) ok = 1'b1;
        end
        if (!ok) bound_expired("response");
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int a0, a1, a2, n0, r0, w0;
        rsp_t r;

        // Reset values while reset is held
        idle(2);
        chk1("rst_cmdReady", cmdReady, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_readReq", readReq, 1'b0);
        chk1("rst_writeReq", writeReq, 1'b0);
        chk1("rst_rspValid", rspValid, 1'b0);
        chk1("rst_rspTimeout", rspTimeout, 1'b0);
        chk("rst_ramAddress", ramAddress, 32'h0);
        chk("rst_ramOut", ramOut, 32'h0);
        chk("rst_rspData", rspData, 32'h0);
        reset = 1'b0;
        idle(2);

        // Load from 0x10
        n0 = q_rsp.size(); r0 = n_rreq;
        issue(1'b0, 32'h10, 32'h0, 1'b0, a0);
        wait_rsp(n0);
        idle(2);
        if (q_rsp.size() > n0) begin
            r = q_rsp[n0];
            chk("load_data", r.data, 32'h12345678);
            chk("load_latency", 32'(r.cyc - a0), 32'd3);
            chk1("load_rspWrite", r.wr, 1'b0);
        end
        chk("load_readReq_pulses", 32'(n_rreq - r0), 32'd1);

        // Unaligned store then load back
        n0 = q_rsp.size(); r0 = n_rreq; w0 = n_wreq;
        issue(1'b1, 32'h21, 32'hDEADBEEF, 1'b0, a0);
        wait_rsp(n0);
        if (q_rsp.size() > n0) begin
            chk1("store_rspWrite", q_rsp[n0].wr, 1'b1);
            chk("store_rspData", q_rsp[n0].data, 32'h0);
            chk("store_latency", 32'(q_rsp[n0].cyc - a0), 32'd3);
        end
        chk("store_ram_bytes", {ram[8'h24], ram[8'h23], ram[8'h22], ram[8'h21]}, 32'hDEADBEEF);
        issue(1'b0, 32'h21, 32'h0, 1'b0, a0);
        wait_rsp(n0 + 1);
        idle(2);
        if (q_rsp.size() > n0 + 1) chk("reload_data", q_rsp[n0 + 1].data, 32'hDEADBEEF);
        chk("st_ld_writeReq_pulses", 32'(n_wreq - w0), 32'd1);
        chk("st_ld_readReq_pulses", 32'(n_rreq - r0), 32'd1);

        // Back-to-back loads with cmdValid held
        n0 = q_rsp.size(); r0 = n_rreq;
        issue(1'b0, 32'h40, 32'h0, 1'b1, a0);
        issue(1'b0, 32'h44, 32'h0, 1'b1, a1);
        issue(1'b0, 32'h48, 32'h0, 1'b0, a2);
        wait_rsp(n0 + 2);
        idle(2);
        chk("b2b_spacing1", 32'(a1 - a0), 32'd4);
        chk("b2b_spacing2", 32'(a2 - a1), 32'd4);
        chk("b2b_readReq_pulses", 32'(n_rreq - r0), 32'd3);
        chk("b2b_rsp_count", 32'(q_rsp.size() - n0), 32'd3);
        if (q_rsp.size() >= n0 + 3) begin
            chk("b2b_data0", q_rsp[n0].data, 32'hA1B2C3D4);
            chk("b2b_data1", q_rsp[n0 + 1].data, 32'h0BADF00D);
            chk("b2b_data2", q_rsp[n0 + 2].data, 32'hCAFEBABE);
        end

        // Wrong-type ack during a load is ignored
        silent = 1'b1;
        n0 = q_rsp.size();
        issue(1'b0, 32'h44, 32'h0, 1'b0, a0);
        @(negedge clk); #1; force_wack = 1'b1;
        @(negedge clk); #1; force_wack = 1'b0;
        idle(2);
        chk("wrongack_no_rsp", 32'(q_rsp.size() - n0), 32'd0);
        force_rack = 1'b1;
        @(negedge clk); #1; force_rack = 1'b0;
        wait_rsp(n0);
        if (q_rsp.size() > n0) begin
            chk("wrongack_data", q_rsp[n0].data, 32'h0BADF00D);
            chk1("wrongack_timeout", q_rsp[n0].to, 1'b0);
        end
        silent = 1'b0;
        idle(3);

        // Reset one cycle after the request pulse drops the transaction
        n0 = q_rsp.size();
        issue(1'b0, 32'h10, 32'h0, 1'b0, a0);
        @(negedge clk); #1; reset = 1'b1;
        @(negedge clk); #1; reset = 1'b0;
        idle(4);
        chk("rstwait_no_rsp", 32'(q_rsp.size() - n0), 32'd0);
        chk1("rstwait_cmdReady", cmdReady, 1'b1);
        chk("rstwait_ramAddress", ramAddress, 32'h0);
        issue(1'b0, 32'h48, 32'h0, 1'b0, a0);
        wait_rsp(n0);
        if (q_rsp.size() > n0) chk("rstwait_next_data", q_rsp[n0].data, 32'hCAFEBABE);
        idle(2);

        // Watchdog with a silent responder
        silent = 1'b1;
        n0 = q_rsp.size();
        issue(1'b0, 32'h40, 32'h0, 1'b0, a0);
        wait_rsp(n0);
        if (q_rsp.size() > n0) begin
            r = q_rsp[n0];
            chk1("to_flag", r.to, 1'b1);
            chk("to_data", r.data, 32'h0);
            chk("to_latency", 32'(r.cyc - a0), 32'd8);
        end
        idle(2);
        chk1("to_cmdReady", cmdReady, 1'b0);
        chk1("to_busy", busy, 1'b1);
        force_rack = 1'b1;
        @(negedge clk); #1; force_rack = 1'b0;
        idle(3);
        chk("to_late_ack_ignored", 32'(q_rsp.size() - n0), 32'd1);
        chk1("to_still_busy", busy, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        chk1("to_reset_cmdReady", cmdReady, 1'b1);
        chk1("to_reset_busy", busy, 1'b0);
        silent = 1'b0;
        n0 = q_rsp.size();
        issue(1'b0, 32'h10, 32'h0, 1'b0, a0);
        wait_rsp(n0);
        if (q_rsp.size() > n0) chk("final_load_data", q_rsp[n0].data, 32'h12345678);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator side of the single-word memory request/acknowledge protocol used between the ALU and its RAM model. Accepts one load or store command at a time from the core's load/store logic, drives `ramAddress`/`ramOut` and a one-cycle `readReq`/`writeReq` pulse, waits for the matching `readAck`/`writeAck`, and returns read data or completion to the core. A watchdog flags a responder that never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, 64: WAIT cycles before declaring timeout; 0 disables the watchdog (16-bit counter).
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmdValid` in 1: core presents a command.
- `cmdReady` out 1: block accepts a command this cycle; equals (state == IDLE).
- `cmdWrite` in 1: 1 = store, 0 = load.
- `cmdAddr` in 32: byte address; no alignment requirement.
- `cmdData` in 32: store data.
- `rspValid` out 1: one-cycle completion strobe.
- `rspWrite` out 1: type of the completed command.
- `rspData` out 32: load data; 0 for stores and timeouts.
- `rspTimeout` out 1: completion was a timeout; qualified by `rspValid`.
- `busy` out 1: state != IDLE.
- `ramAddress` out 32: registered request address.
- `ramOut` out 32: registered store data.
- `readReq` out 1: one-cycle read request pulse.
- `writeReq` out 1: one-cycle write request pulse.
- `ramValue` in 32: read data; sampled only with `readAck`.
- `readAck` in 1: read complete.
- `writeAck` in 1: write complete.

## Operation
- States: IDLE, WAIT, ERROR.
- IDLE: on `cmdValid && cmdReady` at an edge, latch `cmdAddr`→`ramAddress`, `cmdData`→`ramOut` (stores only; loads keep the old `ramOut`), latch type, and set `readReq` (load) or `writeReq` (store) for exactly one cycle. Clear the timeout counter and enter WAIT.
- Request pulse rule: a request signal is never high for more than one cycle. The responder re-samples requests once it returns to idle, so a held level would cause a duplicate access.
- WAIT, load: on `readAck`=1, `rspData` ← `ramValue`, `rspValid`=1, `rspWrite`=0, `rspTimeout`=0; go to IDLE.
- WAIT, store: on `writeAck`=1, `rspData`=0, `rspValid`=1, `rspWrite`=1; go to IDLE.
- Non-matching ack in WAIT (e.g. `writeAck` during a load) is ignored. If both acks arrive together, the matching one completes the command.
- Any ack in IDLE or ERROR is ignored. This covers a stale ack left over from a transaction aborted by reset.
- Watchdog: in WAIT the counter increments every cycle without a matching ack. When it reaches `TIMEOUT_CYCLES` (nonzero): `rspValid`=1, `rspTimeout`=1, `rspData`=0, enter ERROR.
- ERROR: `cmdReady`=0, `busy`=1; the block leaves ERROR only on `reset`.
- `cmdValid` while not ready: the command is not accepted. Core inputs may change freely until acceptance.

## Timing
- Reset values: state IDLE; `ramAddress`, `ramOut`, `rspData` = 0; `readReq`, `writeReq`, `rspValid`, `rspWrite`, `rspTimeout` = 0; counter 0. With state IDLE, `cmdReady`=1 and `busy`=0 immediately after reset.
- Accept at edge A: request high from A to A+1.
- With the codebase RAM model (samples at A+1, acks visible from A+2 to A+3): the block samples ack at A+3; `rspValid` high from A+3 to A+4; `cmdReady`=1 from A+3.
- Load/store latency: 3 edges. Back-to-back throughput: one command per 4 cycles. The next request pulse (A+4 to A+5) lands while the responder is idle.
- `rspValid` and `rspTimeout` are registered and last exactly one cycle.
- Reset mid-WAIT: the transaction is dropped, no `rspValid` is issued, and all outputs return to their reset values.

## Test plan
- Load: preload RAM bytes 0x10..0x13 = 78 56 34 12, issue load 0x10 → `readReq` is a single 1-cycle pulse; `rspValid` 3 edges after accept; `rspData` = 0x12345678; `rspWrite`=0.
- Store then load: store 0xDEADBEEF to 0x21 (unaligned), then load 0x21 → RAM bytes 0x21..0x24 = EF BE AD DE; load returns 0xDEADBEEF; exactly one `writeReq` pulse and one `readReq` pulse.
- Back-to-back: `cmdValid` held with 3 loads → accepts at 4-cycle spacing; exactly 3 `readReq` pulses and 3 `rspValid` strobes, with data in order.
- Wrong-type ack: during a load, inject a spurious `writeAck` pulse → no completion; the later `readAck` completes with correct data.
- Timeout: `TIMEOUT_CYCLES`=8, responder silent → `rspValid`&`rspTimeout` 8 cycles into WAIT; `cmdReady` stays 0; a later `readAck` is ignored; after `reset` the block is IDLE with `cmdReady`=1.
- Reset in WAIT: assert `reset` 1 cycle after a load's request pulse → no `rspValid`; the responder's late `readAck` is ignored; the next load completes normally.
